// File: rtl/img_pkg.sv
// Shared types and defaults for the new-image streaming path.
package img_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    DONE
  } stream_state_t;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_WORD_W   = 128;
  localparam int DEF_PIX_W    = 8;
  localparam int PIX_PER_WORD = DEF_WORD_W / DEF_PIX_W;

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads one memory word and presents it LSB pixel first on a valid/ready port.
module word_serializer
  import img_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic              ready,
  output logic [PIX_W-1:0]  data,
  output logic              valid,
  output logic              last
);

  localparam int PPW  = WORD_W / PIX_W;
  localparam int BC_W = cnt_width(PPW);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(PPW - 1);

  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   byte_cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: the shift register is reset too, so tx_data reads 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      byte_cnt <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      shreg    <= load_data;
      byte_cnt <= '0;
      valid    <= 1'b1;
    end else if (valid && ready) begin
      shreg    <= shreg >> PIX_W;
      byte_cnt <= byte_cnt + 1'b1;
      if (byte_cnt == LAST_BYTE) valid <= 1'b0;
    end
  end

  assign data = shreg[PIX_W-1:0];
  assign last = (byte_cnt == LAST_BYTE);

endmodule

// File: rtl/image_stream_out.sv
// Reads the new-image memory word by word after start and streams it out as pixels.
// Owns the memory address port only while busy; all control outputs are registered.
module image_stream_out
  import img_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int NUM_WORDS = 4096,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_owner,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int WC_W = cnt_width(RD_LAT);
  localparam logic [WC_W-1:0]   LAST_WAIT = WC_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  stream_state_t     state;
  logic [ADDR_W-1:0] word_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              load;
  logic              last_byte;
  logic              xfer;

  assign load = (state == WAIT) && (wait_cnt == LAST_WAIT);
  assign xfer = tx_valid && tx_ready;

  word_serializer #(
    .WORD_W (WORD_W),
    .PIX_W  (PIX_W)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (mem_rdata),
    .ready     (tx_ready),
    .data      (tx_data),
    .valid     (tx_valid),
    .last      (last_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      wait_cnt  <= '0;
      mem_owner <= 1'b0;
      mem_addr  <= '0;
      mem_rd_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // Restart from DONE behaves exactly like a fresh start from IDLE.
          if (start) begin
            state     <= READ;
            word_cnt  <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b1;
            mem_owner <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end
        READ: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) state <= SEND;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        SEND: begin
          if (xfer && last_byte) begin
            if (word_cnt == LAST_WORD) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              mem_owner <= 1'b0;
            end else begin
              state     <= READ;
              word_cnt  <= word_cnt + 1'b1;
              mem_addr  <= word_cnt + 1'b1;
              mem_rd_en <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_out.sv
// Directed bench: a two-word instance for streaming/restart/reset cases, a one-word instance for stalls.
module tb_image_stream_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Two-word instance
  logic         start2;
  logic         tx_ready2 = 1'b1;
  logic         mem_owner2, mem_rd_en2, tx_valid2, busy2, done2;
  logic [12:0]  mem_addr2, addr_q2;
  logic [127:0] mem_rdata2;
  logic [7:0]   tx_data2;

  // One-word instance
  logic         start1;
  logic         tx_ready1;
  logic         mem_owner1, mem_rd_en1, tx_valid1, busy1, done1;
  logic [12:0]  mem_addr1, addr_q1;
  logic [127:0] mem_rdata1;
  logic [7:0]   tx_data1;

  image_stream_out #(.NUM_WORDS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mem_owner(mem_owner2),
    .mem_addr(mem_addr2), .mem_rd_en(mem_rd_en2), .mem_rdata(mem_rdata2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
    .busy(busy2), .done(done2)
  );

  image_stream_out #(.NUM_WORDS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mem_owner(mem_owner1),
    .mem_addr(mem_addr1), .mem_rd_en(mem_rd_en1), .mem_rdata(mem_rdata1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .busy(busy1), .done(done1)
  );

  // Memory model: lane i of word a holds a*0x11 + i, so word 0 is 00..0F and word 1 is 11..20.
  function automatic logic [127:0] mem_word(input logic [12:0] a);
    logic [127:0] w;
    int v;
    for (int i = 0; i < 16; i++) begin
      v = int'(a[7:0]) * 17 + i;
      w[i*8 +: 8] = v[7:0];
    end
    return w;
  endfunction

  function automatic logic [7:0] exp_byte(input int word, input int idx);
    int v;
    v = word * 17 + idx;
    return v[7:0];
  endfunction

  always @(posedge clk or negedge reset)
    if (!reset) addr_q2 <= '0;
    else if (mem_rd_en2) addr_q2 <= mem_addr2;
  always @(posedge clk or negedge reset)
    if (!reset) addr_q1 <= '0;
    else if (mem_rd_en1) addr_q1 <= mem_addr1;
  assign mem_rdata2 = mem_word(addr_q2);
  assign mem_rdata1 = mem_word(addr_q1);

  // Sink for the two-word instance: always ready, or a coin flip per cycle.
  bit rnd_mode = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_ready2 = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitors: transfers, read strobes and stall-stability, all sampled on the falling edge.
  logic [7:0]  rx2[$], rx1[$];
  logic [12:0] ad2[$], ad1[$];
  int          stall_err = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = '0;

  always @(negedge clk) begin
    if (reset && pv && !pr && (!tx_valid2 || tx_data2 !== pd)) stall_err++;
    pv = tx_valid2;
    pr = tx_ready2;
    pd = tx_data2;
    if (tx_valid2 && tx_ready2) rx2.push_back(tx_data2);
    if (mem_rd_en2) ad2.push_back(mem_addr2);
    if (tx_valid1 && tx_ready1) rx1.push_back(tx_data1);
    if (mem_rd_en1) ad1.push_back(mem_addr1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  typedef struct {
    bit rnd;
    bit hold;
    int lat;
    int bytes;
    int reads;
  } vec_t;

  vec_t vecs[4];

  task automatic run_image(input vec_t v, input int row);
    int b0, a0, lat, cyc, nb, na;
    b0 = rx2.size();
    a0 = ad2.size();
    rnd_mode = v.rnd;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    if (!v.hold) start2 = 1'b0;
    check($sformatf("r%0d cycle1 {done,busy,owner,rd_en,addr}", row),
          {done2, busy2, mem_owner2, mem_rd_en2, mem_addr2},
          {1'b0, 1'b1, 1'b1, 1'b1, 13'd0});
    lat = 1;
    while (!tx_valid2 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("r%0d first tx_valid cycle", row), lat, v.lat);
    cyc = 0;
    while (!done2 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("r%0d done reached", row), done2, 1'b1);
    check($sformatf("r%0d end {busy,owner,valid}", row),
          {busy2, mem_owner2, tx_valid2}, 3'b000);
    if (v.hold) start2 = 1'b0;
    repeat (6) @(negedge clk);
    check($sformatf("r%0d done held, no restart", row), {done2, busy2}, 2'b10);
    nb = rx2.size() - b0;
    na = ad2.size() - a0;
    check($sformatf("r%0d byte count", row), nb, v.bytes);
    for (int i = 0; i < nb && i < v.bytes; i++)
      check($sformatf("r%0d byte %0d", row, i), rx2[b0 + i], exp_byte(i / 16, i % 16));
    check($sformatf("r%0d read strobes", row), na, v.reads);
    for (int j = 0; j < na && j < v.reads; j++)
      check($sformatf("r%0d read addr %0d", row, j), ad2[a0 + j], j);
    check($sformatf("r%0d stall stability errors", row), stall_err, 0);
  endtask

  initial begin
    int cyc, cnt, b1, a1, nb;

    vecs[0] = '{rnd: 1'b0, hold: 1'b0, lat: 3, bytes: 32, reads: 2};
    vecs[1] = '{rnd: 1'b1, hold: 1'b0, lat: 3, bytes: 32, reads: 2};
    vecs[2] = '{rnd: 1'b0, hold: 1'b1, lat: 3, bytes: 32, reads: 2};
    vecs[3] = '{rnd: 1'b0, hold: 1'b0, lat: 3, bytes: 32, reads: 2};

    reset     = 1'b0;
    start2    = 1'b0;
    start1    = 1'b0;
    tx_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs dut2",
          {mem_owner2, mem_addr2, mem_rd_en2, tx_data2, tx_valid2, busy2, done2}, '0);
    check("reset outputs dut1",
          {mem_owner1, mem_addr1, mem_rd_en1, tx_data1, tx_valid1, busy1, done1}, '0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Rows: plain stream, random backpressure from DONE, held start, pulsed rerun from DONE.
    for (int r = 0; r < 4; r++) run_image(vecs[r], r);

    // Reset while word 1 byte 5 is on the bus.
    rnd_mode = 1'b0;
    @(posedge clk); #1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(tx_valid2 && tx_data2 == exp_byte(1, 5)) && cyc < 200);
    check("reach word1 byte5", {tx_valid2, tx_data2}, {1'b1, exp_byte(1, 5)});
    reset = 1'b0;
    #1;
    check("mid-stream reset outputs",
          {mem_owner2, mem_addr2, mem_rd_en2, tx_data2, tx_valid2, busy2, done2}, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (tx_valid2 || mem_owner2 || busy2 || mem_rd_en2) cnt++;
    end
    check("idle after reset release", cnt, 0);

    // One-word image with a 20-cycle stall on the first pixel.
    b1 = rx1.size();
    a1 = ad1.size();
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    while (!tx_valid1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("n1 tx_valid rises", tx_valid1, 1'b1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid1 && tx_data1 == 8'h00) cnt++;
    end
    check("n1 pixel 00 held while stalled", cnt, 20);
    @(posedge clk); #1;
    tx_ready1 = 1'b1;
    cyc = 0;
    while (!done1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("n1 final {done,busy,owner,valid}",
          {done1, busy1, mem_owner1, tx_valid1}, 4'b1000);
    nb = rx1.size() - b1;
    check("n1 byte count", nb, 16);
    for (int i = 0; i < nb && i < 16; i++)
      check($sformatf("n1 byte %0d", i), rx1[b1 + i], exp_byte(0, i));
    check("n1 read strobes", ad1.size() - a1, 1);
    if (ad1.size() > a1) check("n1 read addr", ad1[a1], 13'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
